// File: rtl/fp_pkg.sv
// fp_pkg: rounding-mode and flag encodings, operand classes and constant helpers for FP arithmetic
package fp_pkg;
    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;
    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;
    typedef enum logic [2:0] {CL_ZERO, CL_SUB, CL_NORM, CL_INF, CL_QNAN, CL_SNAN} fp_class_e;
    function automatic logic [127:0] fp_qnan(input int e, input int f);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < e; i++) v[f+i] = 1'b1;
        v[f-1] = 1'b1;
        return v;
    endfunction
    function automatic logic [127:0] fp_max_finite(input int e, input int f);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < e + f; i++) v[i] = 1'b1;
        v[f] = 1'b0;
        return v;
    endfunction
endpackage

// File: rtl/fp_round.sv
// fp_round: rounds a normalised mantissa with G/R/S, packs it and flags OF/UF/NX (FP_ADDSUB_FTZ_EN flushes subnormal results)
module fp_round
    import fp_pkg::*;
#(
    parameter int E = 8,
    parameter int F = 23
) (
    input  logic                sign,
    input  logic [F+3:0]        mant,
    input  logic signed [E+1:0] ex,
    input  logic [1:0]          rm,
    output logic [E+F:0]        y,
    output logic                of,
    output logic                uf,
    output logic                nx
);
    localparam int W = E + F + 1;
    localparam int XW = E + 2;
    localparam logic [W-1:0] MAXF = W'(fp_max_finite(E, F));
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << E) - 1);
    logic inexact, up, carry, hidden, ovf, inf_sel;
    logic [F+1:0] sig;
    logic signed [XW-1:0] exp_r;
    always_comb begin
        inexact = |mant[2:0];
        up = rm == RM_RNE ? mant[2] & (mant[1] | mant[0] | mant[3]) :
             rm == RM_RUP ? !sign & inexact :
             rm == RM_RDN ? sign & inexact : 1'b0;
        sig = {1'b0, mant[F+3:3]} + (F+2)'(up);
        carry = sig[F+1];
        hidden = sig[F+1] | sig[F];
        exp_r = ex + XW'(carry);
        ovf = exp_r >= EXP_MAX;
        inf_sel = rm == RM_RNE || (rm == RM_RUP && !sign) || (rm == RM_RDN && sign);
        y = ovf ? (inf_sel ? {sign, {E{1'b1}}, {F{1'b0}}} : {sign, MAXF[E+F-1:0]}) :
            {sign, hidden ? exp_r[E-1:0] : {E{1'b0}}, carry ? sig[F:1] : sig[F-1:0]};
        of = ovf;
        uf = !hidden & inexact;
        nx = inexact | ovf;
`ifdef FP_ADDSUB_FTZ_EN
        if (!hidden && sig != '0) begin
            y = {sign, {(E+F){1'b0}}};
            uf = 1'b1;
            nx = 1'b1;
        end
`endif
    end
endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage IEEE-754 add/sub with valid/ready backpressure (FP_ADDSUB_FTZ_EN enables DAZ/FTZ)
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int E = 8,
    parameter int F = 23,
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [E+F:0]  in_a,
    input  logic [E+F:0]  in_b,
    input  logic          in_sub,
    input  logic [1:0]    in_rm,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [E+F:0]  out_y,
    output logic [4:0]    out_flags,
    output logic [TW-1:0] out_tag
);
    localparam int W = E + F + 1;
    localparam int M = F + 4;
    localparam int XW = E + 2;
    localparam logic [W-1:0] QNAN = W'(fp_qnan(E, F));
    function automatic fp_class_e classify(input logic [E-1:0] ex, input logic [F-1:0] fr);
        return &ex ? (fr == '0 ? CL_INF : fr[F-1] ? CL_QNAN : CL_SNAN) :
               ex == '0 ? (fr == '0 ? CL_ZERO : CL_SUB) : CL_NORM;
    endfunction
    logic s1_valid, s2_valid, s3_valid, s1_ld, s2_ld, s3_ld;
    assign s3_ld = !s3_valid || out_ready;
    assign s2_ld = !s2_valid || s3_ld;
    assign s1_ld = !s1_valid || s2_ld;
    assign in_ready = s1_ld;
    assign out_valid = s3_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            if (s1_ld) s1_valid <= in_valid;
            if (s2_ld) s2_valid <= s1_valid;
            if (s3_ld) s3_valid <= s2_valid;
        end
    end
    logic sa, sb, swap, nan, sp, nv;
    logic [E-1:0] ea, eb, xg, xl, d;
    logic [F-1:0] fa, fb;
    logic [F:0] mg, ml;
    logic [2*M-1:0] sh;
    logic [M-1:0] al;
    logic [W-1:0] sp_y;
    fp_class_e ca, cb;
    always_comb begin
        sa = in_a[W-1];
        sb = in_b[W-1] ^ in_sub;
        ea = in_a[W-2:F];
        eb = in_b[W-2:F];
`ifdef FP_ADDSUB_FTZ_EN
        fa = ea == '0 ? '0 : in_a[F-1:0];
        fb = eb == '0 ? '0 : in_b[F-1:0];
`else
        fa = in_a[F-1:0];
        fb = in_b[F-1:0];
`endif
        ca = classify(ea, fa);
        cb = classify(eb, fb);
        swap = {eb, fb} > {ea, fa};
        mg = {(swap ? eb : ea) != '0, swap ? fb : fa};
        ml = {(swap ? ea : eb) != '0, swap ? fa : fb};
        xg = swap ? (eb == '0 ? E'(1) : eb) : (ea == '0 ? E'(1) : ea);
        xl = swap ? (ea == '0 ? E'(1) : ea) : (eb == '0 ? E'(1) : eb);
        d = xg - xl;
        sh = {ml, 3'b000, {M{1'b0}}} >> d;
        al = int'(d) >= M ? {{(M-1){1'b0}}, |ml} : {sh[2*M-1:M+1], sh[M] | (|sh[M-1:0])};
        nan = ca == CL_QNAN || ca == CL_SNAN || cb == CL_QNAN || cb == CL_SNAN;
        nv = ca == CL_SNAN || cb == CL_SNAN || (ca == CL_INF && cb == CL_INF && sa != sb);
        sp = nan || ca == CL_INF || cb == CL_INF;
        sp_y = (nan || nv) ? QNAN : ca == CL_INF ? {sa, {E{1'b1}}, {F{1'b0}}} : {sb, {E{1'b1}}, {F{1'b0}}};
    end
    logic s1_sign, s1_sub, s1_sp, s1_nv;
    logic [E-1:0] s1_exp;
    logic [M-1:0] s1_mg, s1_ml;
    logic [1:0] s1_rm;
    logic [TW-1:0] s1_tag;
    logic [W-1:0] s1_sp_y;
    always_ff @(posedge clk) begin
        if (s1_ld) begin
            s1_sign <= swap ? sb : sa;
            s1_sub <= sa ^ sb;
            s1_exp <= xg;
            s1_mg <= {mg, 3'b000};
            s1_ml <= al;
            s1_rm <= in_rm;
            s1_tag <= in_tag;
            s1_sp <= sp;
            s1_nv <= nv;
            s1_sp_y <= sp_y;
        end
    end
    logic [M:0] sum;
    logic [M-1:0] nm;
    logic signed [XW-1:0] xe, nexp;
    logic sgn;
    int lz, lim, shamt;
    always_comb begin
        sum = s1_sub ? {1'b0, s1_mg} - {1'b0, s1_ml} : {1'b0, s1_mg} + {1'b0, s1_ml};
        lz = M;
        for (int i = 0; i < M; i++) if (sum[i]) lz = M - 1 - i;
        lim = int'(s1_exp) - 1;
        shamt = lz < lim ? lz : lim;
        xe = $signed({2'b00, s1_exp});
        nexp = sum[M] ? xe + XW'(1) : xe - XW'(shamt);
        nm = sum[M] ? {sum[M:2], |sum[1:0]} : sum[M-1:0] << shamt;
        sgn = sum == '0 ? (s1_sub ? s1_rm == RM_RDN : s1_sign) : s1_sign;
    end
    logic s2_sign, s2_sp, s2_nv;
    logic [M-1:0] s2_mant;
    logic signed [XW-1:0] s2_exp;
    logic [1:0] s2_rm;
    logic [TW-1:0] s2_tag;
    logic [W-1:0] s2_sp_y;
    always_ff @(posedge clk) begin
        if (s2_ld) begin
            s2_sign <= sgn;
            s2_mant <= nm;
            s2_exp <= nexp;
            s2_rm <= s1_rm;
            s2_tag <= s1_tag;
            s2_sp <= s1_sp;
            s2_nv <= s1_nv;
            s2_sp_y <= s1_sp_y;
        end
    end
    logic [W-1:0] r_y;
    logic r_of, r_uf, r_nx;
    logic [4:0] fl;
    fp_round #(.E(E), .F(F)) u_round (
        .sign(s2_sign),
        .mant(s2_mant),
        .ex(s2_exp),
        .rm(s2_rm),
        .y(r_y),
        .of(r_of),
        .uf(r_uf),
        .nx(r_nx)
    );
    always_comb begin
        fl = '0;
        fl[FLG_NV] = s2_sp & s2_nv;
        fl[FLG_OF] = !s2_sp & r_of;
        fl[FLG_UF] = !s2_sp & r_uf;
        fl[FLG_NX] = !s2_sp & r_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_y <= '0;
            out_flags <= '0;
            out_tag <= '0;
        end else if (s3_ld && s2_valid) begin
            out_y <= s2_sp ? s2_sp_y : r_y;
            out_flags <= fl;
            out_tag <= s2_tag;
        end
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Pipelined IEEE-754 add/subtract, parametrised in exponent/fraction width, with a valid/ready handshake, a per-operation rounding mode and an opaque tag. It is the throughput successor of the combinational adder. It sits between the operand-issue stage and the FP result writeback/arbiter. The datapath is 3 registered stages with full backpressure and one result per cycle sustained.

Parameters:
E, 8, exponent bits (E >= 3)
F, 23, fraction bits (F >= 4)
TW, 4, tag width carried alongside each operation

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  pipe accepts operation this cycle
in_a  in  1+E+F  operand A {sign, exp, frac}
in_b  in  1+E+F  operand B
in_sub  in  1  0 = A+B, 1 = A-B
in_rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf)
in_tag  in  TW  opaque id, returned unchanged
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_y  out  1+E+F  result
out_flags  out  5  {NV, DZ, OF, UF, NX}; DZ is always 0
out_tag  out  TW  tag of the result

Behaviour:
- Transfer occurs when valid && ready on a side at the rising edge.
- Stage S1: unpack, classify (zero/sub/normal/inf/qNaN/sNaN), swap so |A| >= |B|, align the smaller operand with G/R/S plus sticky. Shifts >= F+4 collapse to sticky only.
- Stage S2: add or subtract magnitudes in F+5 bits. Normalise by 1-bit right shift on carry, or by leading-zero count on cancellation. The left shift is clamped so the exponent does not go below 1 (subnormal result).
- Stage S3: round per in_rm from G/R/S, handle mantissa carry-out (exponent +1), pack, and set flags.
- Each stage holds a valid bit. A stage loads when it is empty or its contents move forward this cycle.
- in_ready = !s1_valid || s1_advances. Bubbles compress.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput is 1/cycle.
- While out_valid && !out_ready: out_y, out_flags and out_tag stay stable, and upstream stalls only as far as needed.
- rst: all valid bits 0, and out_y, out_flags, out_tag are 0 in the same cycle. In-flight operations are discarded and not replayed. in_ready = 1 on the first cycle after rst deasserts.
- NaN input: result is the canonical qNaN {0, all-ones, 1, 0...}. NV is set only if an input is an sNaN.
- Inf - Inf with effective opposite signs: canonical qNaN, NV.
- Inf op finite: the infinity with its effective sign, no flags.
- Exact zero result from nonzero operands: +0, except RDN gives -0.
- (+-0)+(+-0): if the effective signs are equal, that sign; otherwise +0 (RDN: -0).
- Overflow sets OF and NX:
  - RNE: +-Inf.
  - RTZ: +-max-finite.
  - RUP: +Inf for positive, -max-finite for negative.
  - RDN: the mirror of RUP.
- NX is set when any of G/R/S is nonzero after alignment/normalisation.
- UF is set when the result is tiny after rounding and inexact.
- Exponent arithmetic is E+2 bits signed internally. No silent wrap.

Optional Feature:
FP_ADDSUB_FTZ_EN.
- Defined: subnormal inputs are treated as signed zero (DAZ). Subnormal results flush to signed zero and set UF and NX. No subnormal result is ever emitted.
- Undefined: full gradual-underflow support as described above.

Decomposition:
- Package fp_pkg holds:
  - rounding-mode encodings RM_RNE/RM_RTZ/RM_RDN/RM_RUP;
  - flag bit indices FLG_NV..FLG_NX;
  - the class enumeration;
  - helper functions for canonical qNaN and max-finite for given E/F.
- Sub-module fp_round (combinational, S3): takes sign, normalised mantissa with GRS, exponent and rm; returns the packed result plus OF/UF/NX. It is reusable by future mul/fma blocks.

Test Plan:
1. E=8, F=23, RNE: 0x3F800000 + 0x3F800000 -> 0x40000000 after exactly 3 cycles, flags 0, tag echoed.
2. 0x3F800000 - 0x3F800000: RNE -> 0x00000000; RDN -> 0x80000000; flags 0.
3. 0x7F800000 + 0xFF800000 -> 0x7FC00000, NV. Input 0x7F800001 (sNaN) + 1.0 -> 0x7FC00000, NV. Input 0x7FC00001 + 1.0 -> 0x7FC00000, no flags.
4. 0x7F7FFFFF + 0x7F7FFFFF: RNE -> 0x7F800000, OF|NX; RTZ -> 0x7F7FFFFF, OF|NX.
5. 0x00800000 - 0x00400000 -> 0x00400000 (subnormal), flags 0. With FP_ADDSUB_FTZ_EN: input 0x00400000 is treated as 0, giving result 0x00800000.
6. Stream 8 ops back-to-back while out_ready toggles 1,0,0,1...: no loss, duplication or reordering (tags 0..7 in order). Outputs stay stable under stall. Asserting rst mid-stream leaves out_valid = 0 on the next cycle.
